// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int CHECKSUM_W = 8;

endpackage

// File: rtl/instr_loader_word_packer.sv
// Packs accepted payload bytes into little-endian 32-bit words; pulses word_done on the 4th byte.
module instr_loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // The final byte bypasses the register so the full word is available on the completing edge.
  assign word      = {byte_in, low_bytes};
  assign word_done = accept && (lane == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      lane      <= 2'd0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_in;
        2'd1:    low_bytes[15:8]  <= byte_in;
        2'd2:    low_bytes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Receives a length-prefixed, checksummed byte image and writes it into instruction memory,
// holding the core in reset until the image is verified.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              load_en_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic [31:0]       load_instr_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int unsigned MAX_WORDS = 2**ADDR_W;

  state_t                state;
  logic [CNT_W-1:0]      word_total;
  logic [ADDR_W:0]       word_cnt;
  logic [CHECKSUM_W-1:0] checksum;

  logic             accept;
  logic             pack_clear;
  logic             pack_accept;
  logic             word_done;
  logic [31:0]      packed_word;
  logic [CNT_W-1:0] hdr_count;
  logic [CNT_W-1:0] next_words;

  assign accept      = byte_valid_i && byte_ready_o;
  assign pack_clear  = start_i && (state == IDLE || state == DONE || state == ERROR);
  assign pack_accept = accept && (state == PAYLOAD);
  assign hdr_count   = CNT_W'({byte_i, word_total[7:0]});
  assign next_words  = CNT_W'(word_cnt) + CNT_W'(1);

  instr_loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .accept    (pack_accept),
    .byte_in   (byte_i),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_ready_o <= 1'b0;
      load_en_o    <= 1'b0;
      load_addr_o  <= '0;
      load_instr_o <= 32'd0;
      core_rst_o   <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      word_total   <= '0;
      word_cnt     <= '0;
      checksum     <= '0;
    end else begin
      load_en_o <= 1'b0;
      // Output word register is separate from the packer so the next byte can land during the strobe.
      if (word_done) begin
        load_en_o    <= 1'b1;
        load_instr_o <= packed_word;
        load_addr_o  <= word_cnt[ADDR_W-1:0];
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state        <= HDR0;
            byte_ready_o <= 1'b1;
            core_rst_o   <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            word_total   <= '0;
            word_cnt     <= '0;
            checksum     <= '0;
          end
        end
        HDR0: begin
          if (accept) begin
            word_total[7:0] <= byte_i;
            state           <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            word_total <= hdr_count;
            if (hdr_count == '0) begin
              state <= CHECK;
            end else if (32'(hdr_count) > MAX_WORDS) begin
              state        <= ERROR;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              error_o      <= 1'b1;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            checksum <= checksum + byte_i;
            if (word_done) begin
              word_cnt <= word_cnt + 1'b1;
              if (next_words == word_total) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            if (byte_i == checksum) begin
              state      <= DONE;
              done_o     <= 1'b1;
              core_rst_o <= 1'b0;
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued, a negedge monitor checks strobes.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        load_en_o;
  logic [7:0]  load_addr_o;
  logic [31:0] load_instr_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int tests = 0;
  int fails = 0;
  logic [39:0] exp_q[$];

  instr_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .load_en_o    (load_en_o),
    .load_addr_o  (load_addr_o),
    .load_instr_o (load_instr_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (load_en_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0h instr %0h expected no write", load_addr_o, load_instr_o);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({load_addr_o, load_instr_o} !== e) begin
          fails++;
          $display("FAIL write: got %0h/%08h expected %0h/%08h", load_addr_o, load_instr_o, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit in_payload, input bit jitter);
    int n;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        byte_valid_i = 1'b0;
        if (in_payload) chk("ready_gap", byte_ready_o, 1);
      end
    end
    @(negedge clk);
    byte_i       = b;
    byte_valid_i = 1'b1;
    if (in_payload) chk("ready_payload", byte_ready_o, 1);
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got byte_ready_o=%0b expected 1 within 20 cycles", byte_ready_o);
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  // Sends header, payload and trailer; the last byte is the trailer. Checks core_rst before the trailer.
  task automatic send_stream(input logic [7:0] s[$], input bit jitter);
    for (int i = 0; i < s.size(); i++) begin
      if (i == s.size() - 1) chk("core_rst_before_trailer", core_rst_o, 1);
      send_byte(s[i], (i >= 2 && i < s.size() - 1), jitter);
    end
  endtask

  task automatic expect_good_writes();
    exp_q.push_back({8'h00, 32'h00500093});
    exp_q.push_back({8'h01, 32'h00000013});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},    byte_ready_o, 0);
    chk({tag, "_load_en"},  load_en_o, 0);
    chk({tag, "_addr"},     load_addr_o, 0);
    chk({tag, "_instr"},    load_instr_o, 0);
    chk({tag, "_core_rst"}, core_rst_o, 1);
    chk({tag, "_busy"},     busy_o, 0);
    chk({tag, "_done"},     done_o, 0);
    chk({tag, "_error"},    error_o, 0);
  endtask

  logic [7:0] good_s[$];
  logic [7:0] bad_s[$];
  logic [7:0] big_s[$];
  logic [7:0] zero_s[$];
  logic [7:0] part_s[$];

  initial begin
    good_s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hF6};
    bad_s  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hF5};
    big_s  = '{8'h01, 8'h01};
    zero_s = '{8'h00, 8'h00, 8'h00};
    part_s = '{8'h02, 8'h00, 8'h93, 8'h00};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Good image
    pulse_start();
    chk("start_busy", busy_o, 1);
    chk("start_ready", byte_ready_o, 1);
    expect_good_writes();
    send_stream(good_s, 1'b0);
    chk("good_core_rst_fall", core_rst_o, 0);
    chk("good_done", done_o, 1);
    chk("good_error", error_o, 0);
    chk("good_busy", busy_o, 0);
    chk("good_ready", byte_ready_o, 0);
    repeat (2) @(negedge clk);
    chk("good_writes_pending", exp_q.size(), 0);

    // Bad trailer, restart from DONE
    pulse_start();
    chk("restart_done_clr", done_o, 0);
    chk("restart_core_rst", core_rst_o, 1);
    expect_good_writes();
    send_stream(bad_s, 1'b0);
    chk("bad_error", error_o, 1);
    chk("bad_done", done_o, 0);
    chk("bad_core_rst", core_rst_o, 1);
    repeat (2) @(negedge clk);
    chk("bad_writes_pending", exp_q.size(), 0);

    // Recover from ERROR
    pulse_start();
    chk("restart_err_clr", error_o, 0);
    expect_good_writes();
    send_stream(good_s, 1'b0);
    chk("recover_done", done_o, 1);
    chk("recover_core_rst", core_rst_o, 0);
    repeat (2) @(negedge clk);
    chk("recover_writes_pending", exp_q.size(), 0);

    // Oversized header: N = 257
    pulse_start();
    send_byte(big_s[0], 1'b0, 1'b0);
    send_byte(big_s[1], 1'b0, 1'b0);
    chk("big_error", error_o, 1);
    chk("big_ready", byte_ready_o, 0);
    chk("big_core_rst", core_rst_o, 1);
    chk("big_busy", busy_o, 0);
    repeat (3) @(negedge clk);

    // Empty image
    pulse_start();
    send_stream(zero_s, 1'b0);
    chk("zero_done", done_o, 1);
    chk("zero_error", error_o, 0);
    chk("zero_core_rst", core_rst_o, 0);
    repeat (2) @(negedge clk);

    // Good image with stalls on byte_valid_i
    pulse_start();
    expect_good_writes();
    send_stream(good_s, 1'b1);
    chk("jitter_done", done_o, 1);
    chk("jitter_core_rst", core_rst_o, 0);
    repeat (2) @(negedge clk);
    chk("jitter_writes_pending", exp_q.size(), 0);

    // Reset after the 2nd payload byte
    pulse_start();
    send_stream(part_s, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_done", done_o, 0);
    chk("midrst_core_rst", core_rst_o, 1);

    // Full image after the aborted one must not inherit the partial word
    pulse_start();
    expect_good_writes();
    send_stream(good_s, 1'b0);
    chk("post_rst_done", done_o, 1);
    repeat (2) @(negedge clk);
    chk("post_rst_writes_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
